// File: rtl/nn4h_act_pkg.sv
// rtl/nn4h_act_pkg.sv - shared activation-unit mode encodings and helpers
package nn4h_act_pkg;

  typedef enum logic [1:0] {
    ACT_MODE_INTERP = 2'd0,
    ACT_MODE_RELU   = 2'd1,
    ACT_MODE_BYPASS = 2'd2
  } act_mode_t;

  // Encoding 3 is an alias of bypass, so fold it here before it enters the pipe.
  function automatic act_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return ACT_MODE_INTERP;
      2'd1:    return ACT_MODE_RELU;
      default: return ACT_MODE_BYPASS;
    endcase
  endfunction

  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                     input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/act_interp_lane.sv
// rtl/act_interp_lane.sv - S2/S3 interpolation arithmetic for one lane
module act_interp_lane
  import nn4h_act_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en2,
  input  logic              en3,
  input  act_mode_t         mode2,
  input  logic [DATA_W-1:0] z1,
  input  logic [DATA_W-1:0] base1,
  input  logic [DATA_W-1:0] next1,
  output logic [DATA_W-1:0] r
);

  localparam int PROD_W = DATA_W + FRAC_W + 2;
  localparam int SUM_W  = PROD_W + 1;
  localparam logic signed [PROD_W-1:0] HALF =
    {{(PROD_W - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};

  logic signed [DATA_W:0]   diff;
  logic signed [FRAC_W:0]   rem_s;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [PROD_W-1:0] prod2;
  logic signed [PROD_W-1:0] rnd;
  logic signed [PROD_W-1:0] shifted;
  logic signed [SUM_W-1:0]  sum;
  logic signed [DATA_W-1:0] base2;
  logic [DATA_W-1:0]        z2;
  logic [DATA_W-1:0]        interp_r;
  logic [DATA_W-1:0]        r_c;

  assign diff   = $signed({next1[DATA_W-1], next1}) - $signed({base1[DATA_W-1], base1});
  assign rem_s  = $signed({1'b0, z1[FRAC_W-1:0]});
  assign prod_c = PROD_W'(diff) * PROD_W'(rem_s);

  // Round half-up, then rescale back to the table's fixed-point grid.
  assign rnd      = prod2 + HALF;
  assign shifted  = rnd >>> FRAC_W;
  assign sum      = SUM_W'(base2) + SUM_W'(shifted);
  assign interp_r = DATA_W'(sat_signed(64'(sum), DATA_W));

  always_comb begin
    r_c = interp_r;
    case (mode2)
      ACT_MODE_RELU:   r_c = z2[DATA_W-1] ? '0 : z2;
      ACT_MODE_BYPASS: r_c = z2;
      default:         r_c = interp_r;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base2 <= '0;
      z2    <= '0;
      prod2 <= '0;
      r     <= '0;
    end else begin
      if (en2) begin
        base2 <= base1;
        z2    <= z1;
        prod2 <= prod_c;
      end
      if (en3) r <= r_c;
    end
  end

endmodule

// File: rtl/act_interp_pipe.sv
// rtl/act_interp_pipe.sv - multi-lane piecewise-linear activation pipeline with table
module act_interp_pipe
  import nn4h_act_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 24,
  parameter int LANES  = 4,
  parameter int TAG_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic [TAG_W-1:0]           out_tag,
  input  logic                       tbl_we,
  input  logic [DATA_W-FRAC_W-1:0]   tbl_addr,
  input  logic [DATA_W-1:0]          tbl_wdata
);

  localparam int IDX_W = DATA_W - FRAC_W;
  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] IDX_MAXP = {1'b0, {(IDX_W - 1){1'b1}}};

  logic [DATA_W-1:0] tbl [DEPTH];

  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  logic en2, en3;
  act_mode_t mode_in, mode1, mode2;
  logic [TAG_W-1:0] tag1, tag2;
  logic [DATA_W-1:0] z1    [LANES];
  logic [DATA_W-1:0] base1 [LANES];
  logic [DATA_W-1:0] next1 [LANES];
  logic [IDX_W-1:0]  idx   [LANES];
  logic [IDX_W-1:0]  nidx  [LANES];

  // Each stage may load when the one after it is empty or draining this cycle.
  assign ld3       = !v3 || out_ready;
  assign ld2       = !v2 || ld3;
  assign ld1       = !v1 || ld2;
  assign en2       = ld2 && v1;
  assign en3       = ld3 && v2;
  assign in_ready  = ld1;
  assign out_valid = v3;
  assign mode_in   = decode_mode(mode);

  // The upper neighbour of the largest positive index is clamped, not wrapped.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      idx[k]  = in_data[k*DATA_W+FRAC_W +: IDX_W];
      nidx[k] = (idx[k] == IDX_MAXP) ? idx[k] : idx[k] + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (tbl_we) begin
      tbl[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
      if (ld3) v3 <= v2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode1   <= ACT_MODE_INTERP;
      mode2   <= ACT_MODE_INTERP;
      tag1    <= '0;
      tag2    <= '0;
      out_tag <= '0;
      for (int k = 0; k < LANES; k++) begin
        z1[k]    <= '0;
        base1[k] <= '0;
        next1[k] <= '0;
      end
    end else begin
      if (ld1 && in_valid) begin
        mode1 <= mode_in;
        tag1  <= in_tag;
        for (int k = 0; k < LANES; k++) begin
          z1[k] <= in_data[k*DATA_W +: DATA_W];
          if (mode_in == ACT_MODE_INTERP) begin
            base1[k] <= tbl[idx[k]];
            next1[k] <= tbl[nidx[k]];
          end else begin
            base1[k] <= '0;
            next1[k] <= '0;
          end
        end
      end
      if (en2) begin
        mode2 <= mode1;
        tag2  <= tag1;
      end
      if (en3) out_tag <= tag2;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    act_interp_lane #(
      .DATA_W(DATA_W),
      .FRAC_W(FRAC_W)
    ) u_lane (
      .clk   (clk),
      .rst   (rst),
      .en2   (en2),
      .en3   (en3),
      .mode2 (mode2),
      .z1    (z1[k]),
      .base1 (base1[k]),
      .next1 (next1[k]),
      .r     (out_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_act_interp_pipe.sv
// tb/tb_act_interp_pipe.sv - scoreboard bench for act_interp_pipe against a reference model
module tb_act_interp_pipe;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 24;
  localparam int LANES  = 4;
  localparam int TAG_W  = 8;
  localparam int BW     = LANES * DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        mode;
  logic              in_valid;
  logic              in_ready;
  logic [BW-1:0]     in_data;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_data;
  logic [TAG_W-1:0]  out_tag;
  logic              tbl_we;
  logic [7:0]        tbl_addr;
  logic [DATA_W-1:0] tbl_wdata;

  act_interp_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [BW-1:0]    data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int occ = 0;
  bit last_ir;
  int last_occ;
  logic signed [DATA_W-1:0] tbl_m [256];

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Spec-level model: linear blend between neighbouring samples, half-up rounding.
  function automatic logic [DATA_W-1:0] ref_lane(input logic [DATA_W-1:0] z, input logic [1:0] m);
    logic [7:0] i, ni;
    longint b, n, rem, q, r;
    if (m == 2'd1) return z[31] ? 32'd0 : z;
    if (m != 2'd0) return z;
    i   = z[31:24];
    ni  = (i == 8'h7F) ? i : i + 8'd1;
    b   = tbl_m[i];
    n   = tbl_m[ni];
    rem = z[23:0];
    q   = ((n - b) * rem + 64'sd8388608) >>> 24;
    r   = b + q;
    if (r > 64'sd2147483647) r = 64'sd2147483647;
    if (r < -64'sd2147483648) r = -64'sd2147483648;
    return r[31:0];
  endfunction

  function automatic logic [BW-1:0] ref_beat(input logic [BW-1:0] d, input logic [1:0] m);
    logic [BW-1:0] res;
    for (int k = 0; k < LANES; k++) res[k*DATA_W +: DATA_W] = ref_lane(d[k*DATA_W +: DATA_W], m);
    return res;
  endfunction

  // One clock: called just after a negedge with inputs set, returns at the next negedge.
  task automatic cycle(input bit um, input logic [BW-1:0] e, output bit a);
    bit p;
    #1;
    chk("in_ready_rule", BW'(in_ready), BW'((occ < 3) || out_ready));
    last_ir  = in_ready;
    last_occ = occ;
    a = in_valid && in_ready;
    p = out_valid && out_ready;
    if (a) sb.push_back('{data: (um ? ref_beat(in_data, mode) : e), tag: in_tag});
    if (tbl_we) tbl_m[tbl_addr] = tbl_wdata;
    @(negedge clk);
    occ = occ + int'(a) - int'(p);
  endtask

  task automatic idle();
    bit a;
    in_valid = 1'b0;
    tbl_we   = 1'b0;
    cycle(1'b1, '0, a);
  endtask

  task automatic load(input logic [7:0] addr, input logic [DATA_W-1:0] val);
    bit a;
    in_valid  = 1'b0;
    tbl_we    = 1'b1;
    tbl_addr  = addr;
    tbl_wdata = val;
    cycle(1'b1, '0, a);
    tbl_we = 1'b0;
  endtask

  task automatic send(input logic [1:0] m, input logic [BW-1:0] d, input logic [TAG_W-1:0] t,
                      input bit um, input logic [BW-1:0] e);
    bit a;
    int n;
    n = 0;
    in_valid = 1'b1;
    mode     = m;
    in_data  = d;
    in_tag   = t;
    do begin
      cycle(um, e, a);
      n++;
    end while (!a && n < 50);
    in_valid = 1'b0;
    if (!a) chk("send_timeout", BW'(0), BW'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      idle();
      n++;
    end
    chk("drain_empty", BW'(sb.size()), BW'(0));
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  initial begin : monitor
    bit stall_p;
    logic [BW-1:0] d_p;
    logic [TAG_W-1:0] t_p;
    exp_t e;
    stall_p = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        stall_p = 1'b0;
        chk("rst_out_valid", BW'(out_valid), BW'(0));
      end else begin
        if (stall_p) begin
          chk("stall_valid", BW'(out_valid), BW'(1));
          chk("stall_data", out_data, d_p);
          chk("stall_tag", BW'(out_tag), BW'(t_p));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", BW'(out_tag), BW'(0) - BW'(1));
          end else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.data);
            chk("out_tag", BW'(out_tag), BW'(e.tag));
          end
        end
        stall_p = out_valid && !out_ready;
        d_p = out_data;
        t_p = out_tag;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    bit a;
    int n, i, occ_low;
    logic [BW-1:0] d;

    rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_data = '0; in_tag = '0;
    out_ready = 1'b1; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    for (int k = 0; k < 256; k++) tbl_m[k] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", BW'(in_ready), BW'(1));
    chk("reset_out_valid", BW'(out_valid), BW'(0));
    chk("reset_out_data", out_data, '0);
    chk("reset_out_tag", BW'(out_tag), BW'(0));
    @(negedge clk);

    // Identity table and latency
    for (int k = 0; k < 256; k++) load(8'(k), 32'(k) << 24);
    send(2'd0, {LANES{32'h015FFB80}}, 8'h11, 1'b0, {LANES{32'h015FFB80}});
    n = 1;
    while (!out_valid && n < 10) begin idle(); n++; end
    chk("latency", BW'(n), BW'(3));
    drain();

    // Midpoint and exact-sample interpolation
    load(8'd1, 32'h00BB0000);
    load(8'd2, 32'h00E10000);
    send(2'd0, {LANES{32'h01800000}}, 8'h21, 1'b0, {LANES{32'h00CE0000}});
    send(2'd0, {LANES{32'h01000000}}, 8'h22, 1'b0, {LANES{32'h00BB0000}});
    send(2'd0, {32'h01400000, 32'h01C00000, 32'h00800000, 32'h02000000}, 8'h23, 1'b1, '0);
    drain();

    // Top-of-range clamp
    load(8'h7F, 32'h01000000);
    load(8'h80, 32'h80000000);
    send(2'd0, {LANES{32'h7F800000}}, 8'h31, 1'b0, {LANES{32'h01000000}});
    send(2'd0, {LANES{32'h7FFFFFFF}}, 8'h32, 1'b0, {LANES{32'h01000000}});
    drain();

    // ReLU and bypass
    send(2'd1, {LANES{32'hFF000000}}, 8'h41, 1'b0, '0);
    send(2'd1, {LANES{32'h00400000}}, 8'h42, 1'b0, {LANES{32'h00400000}});
    send(2'd2, {LANES{32'h80000000}}, 8'h43, 1'b0, {LANES{32'h80000000}});
    send(2'd3, {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'hFFFFFFFF}, 8'h44, 1'b0,
         {32'h12345678, 32'h9ABCDEF0, 32'h0, 32'hFFFFFFFF});
    send(2'd0, {LANES{32'h01800000}}, 8'h45, 1'b0, {LANES{32'h00CE0000}});
    drain();

    // Tagged stream with output stall in cycles 4..8
    i = 0;
    occ_low = -1;
    for (int c = 0; c < 60 && (i < 8 || sb.size() != 0); c++) begin
      out_ready = !(c >= 4 && c <= 8);
      in_valid  = (i < 8);
      mode      = 2'd0;
      for (int k = 0; k < LANES; k++) in_data[k*DATA_W +: DATA_W] = $urandom;
      in_tag    = 8'(i + 1);
      cycle(1'b1, '0, a);
      if (a) i++;
      if (!last_ir && occ_low < 0) occ_low = last_occ;
    end
    in_valid = 1'b0;
    chk("stream_count", BW'(i), BW'(8));
    chk("held_at_stall", BW'(occ_low), BW'(3));
    drain();

    // Random traffic with concurrent table writes
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      mode      = 2'($urandom_range(0, 3));
      for (int k = 0; k < LANES; k++) in_data[k*DATA_W +: DATA_W] = $urandom;
      in_tag    = 8'($urandom);
      tbl_we    = ($urandom_range(0, 3) == 0);
      tbl_addr  = 8'($urandom);
      tbl_wdata = $urandom;
      out_ready = ($urandom_range(0, 9) < 7);
      cycle(1'b1, '0, a);
    end
    tbl_we = 1'b0;
    drain();

    // Reset with two beats in flight
    send(2'd0, {LANES{32'h01800000}}, 8'h61, 1'b1, '0);
    send(2'd2, {LANES{32'h00000005}}, 8'h62, 1'b1, '0);
    rst = 1'b1;
    sb.delete();
    occ = 0;
    for (int k = 0; k < 256; k++) tbl_m[k] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      idle();
      chk("post_rst_quiet", BW'(out_valid), BW'(0));
    end
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < LANES; k++) d[k*DATA_W +: DATA_W] = $urandom;
      send(2'd0, d, 8'(8'h70 + c), 1'b0, '0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
